filter_share_ctrl: RTL



---
 rtl/filter_pkg.sv | 21 ++
 rtl/filter_tap_sum.sv | 43 ++++
 rtl/filter_share_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the shared 4-tap weighted-average filter controller.
// Build option: define SATURATE_EN to clamp results instead of wrapping.
package filter_pkg;

    // Controller states; the encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Right-shift applied to each tap: y = x0 + x1/2 + x2/4 + x3/8.
    localparam int TAP_SH0 = 0;
    localparam int TAP_SH1 = 1;
    localparam int TAP_SH2 = 2;
    localparam int TAP_SH3 = 3;

    // Default sample/result width.
    localparam int DEFAULT_DW = 8;

endpackage

// File: rtl/filter_tap_sum.sv
// Combinational 4-tap weighted sum. Each tap is floor-shifted on its own
// before summing; the sum is formed two bits wider than a sample.
// Build option: SATURATE_EN clamps to all-ones, otherwise the low DW bits wrap.
module filter_tap_sum
    import filter_pkg::*;
#(
    parameter int DW = DEFAULT_DW
)(
    input  logic [DW-1:0] x0,
    input  logic [DW-1:0] x1,
    input  logic [DW-1:0] x2,
    input  logic [DW-1:0] x3,
    output logic [DW-1:0] y
);

    localparam int SW = DW + 2;

    function automatic logic [SW-1:0] tap_total(
        input logic [DW-1:0] a0,
        input logic [DW-1:0] a1,
        input logic [DW-1:0] a2,
        input logic [DW-1:0] a3
    );
        return (SW'(a0) >> TAP_SH0) + (SW'(a1) >> TAP_SH1)
             + (SW'(a2) >> TAP_SH2) + (SW'(a3) >> TAP_SH3);
    endfunction

`ifdef SATURATE_EN
    logic [SW-1:0] sum;

    // Clamp the wide sum to the largest representable result.
    always_comb begin
        sum = tap_total(x0, x1, x2, x3);
        y   = (sum > SW'({DW{1'b1}})) ? {DW{1'b1}} : sum[DW-1:0];
    end
`else
    // Keep only the low DW bits of the wide sum (modulo wrap).
    always_comb begin
        y = DW'(tap_total(x0, x1, x2, x3));
    end
`endif

endmodule

// File: rtl/filter_share_ctrl.sv
// Shares one filter_tap_sum datapath across NUM_CH sample channels.
// Round-robin arbiter, per-channel 3-deep history and the IDLE/CALC/OUT FSM.
// Build option: SATURATE_EN (handled inside filter_tap_sum).
module filter_share_ctrl
    import filter_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DW     = DEFAULT_DW,
    localparam int CHW    = $clog2(NUM_CH)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*DW-1:0] ch_data,
    output logic [NUM_CH-1:0]    ch_gnt,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [CHW-1:0]       out_ch,
    output logic                 busy
);

    localparam logic [CHW:0] NCH = (CHW+1)'(NUM_CH);

    state_t          state;
    logic [CHW-1:0]  rr_ptr;
    logic [CHW-1:0]  sel;
    logic [DW-1:0]   x0;
    logic            flush_pend;
    // hist[c][0..2] hold x1..x3 of channel c (most recent first).
    logic [DW-1:0]   hist [NUM_CH][3];

    logic [DW-1:0]   samp [NUM_CH];
    logic            gnt_found;
    logic [CHW-1:0]  gnt_idx;
    logic            grant_ok;
    logic [DW-1:0]   tap_y;

    // Unpack the flat sample bus into one word per channel.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            samp[i] = ch_data[i*DW +: DW];
        end
    end

    // Find the first requester at or above rr_ptr, wrapping past NUM_CH-1.
    // NOTE: every variable assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        logic [CHW:0] pos;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        pos       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos = {1'b0, rr_ptr} + (CHW+1)'(i);
            if (pos >= NCH) pos = pos - NCH;
            if (!gnt_found && ch_req[pos[CHW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = pos[CHW-1:0];
            end
        end
    end

    // Grants are only offered in IDLE and never in a cycle that clears histories.
    assign grant_ok = (state == IDLE) && !flush && !flush_pend;

    // One-hot grant decode of the arbiter choice.
    always_comb begin
        ch_gnt = '0;
        if (grant_ok && gnt_found) ch_gnt[gnt_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    filter_tap_sum #(.DW(DW)) u_tap_sum (
        .x0 (x0),
        .x1 (hist[sel][0]),
        .x2 (hist[sel][1]),
        .x3 (hist[sel][2]),
        .y  (tap_y)
    );

    // Controller FSM with registered result port, history update and flush handling.
    // NOTE: the history array is reset explicitly because a cleared history is part of the reset behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            sel        <= '0;
            x0         <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < 3; k++) hist[c][k] <= '0;
            end
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE: begin
                    if (flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        for (int c = 0; c < NUM_CH; c++) begin
                            for (int k = 0; k < 3; k++) hist[c][k] <= '0;
                        end
                    end else if (gnt_found) begin
                        x0     <= samp[gnt_idx];
                        sel    <= gnt_idx;
                        rr_ptr <= (gnt_idx == CHW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (flush) flush_pend <= 1'b1;
                    out_data     <= tap_y;
                    out_ch       <= sel;
                    out_valid    <= 1'b1;
                    hist[sel][0] <= x0;
                    hist[sel][1] <= hist[sel][0];
                    hist[sel][2] <= hist[sel][1];
                    state        <= OUT;
                end
                OUT: begin
                    if (flush) flush_pend <= 1'b1;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
